control_cmd_master: RTL and testbench

Host-side command initiator for the simulator control word protocol. It turns single high-level requests into the 16-bit command word sequences the on-chip control unit decodes. It streams configuration payload and relays the stats words that come back. It also parses the 4-word state report into status registers. The block sits between the host-side request logic and the 16-bit UART word link, in the opposite direction to the control unit.

---
 rtl/control_cmd_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_control_cmd_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_master.sv
// Host-side command initiator: turns single requests into 16-bit control words,
// streams config payload, relays stats words and parses the 4-word state report.
module control_cmd_master #(
  parameter int RX_TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [23:0] cmd_arg,
  input  logic [15:0] cfg_word,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [15:0] tx_word,
  output logic        tx_word_valid,
  input  logic        tx_ack,
  input  logic [15:0] rx_word,
  input  logic        rx_word_valid,
  output logic [15:0] data_word,
  output logic        data_valid,
  output logic        st_sim_error,
  output logic [3:0]  st_control,
  output logic        st_quiescent,
  output logic [9:0]  st_sim_time,
  output logic [23:0] st_timer,
  output logic        st_valid,
  output logic        busy,
  output logic        error
);
  // state      | meaning
  // IDLE       | accept requests
  // SEND_HDR   | header word on the link
  // SEND_ARG   | TIMER_HI or length word on the link
  // SEND_CFG   | N payload words from cfg_word
  // WAIT_DATA  | relay N stats words
  // WAIT_STATE | collect the 4 state words
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_HDR, S_SEND_ARG, S_SEND_CFG, S_WAIT_DATA, S_WAIT_STATE
  } state_t;

  localparam logic [15:0] RX_TO = 16'(RX_TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [23:0] arg_q, arg_d;
  logic [15:0] tx_word_q, tx_word_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [15:0] data_word_q, data_word_d;
  logic        data_valid_q, data_valid_d;
  logic        stg_err_q, stg_err_d;
  logic [3:0]  stg_ctrl_q, stg_ctrl_d;
  logic        stg_quiet_q, stg_quiet_d;
  logic [9:0]  stg_time_q, stg_time_d;
  logic [15:0] stg_tlo_q, stg_tlo_d;
  logic        st_err_q, st_err_d;
  logic [3:0]  st_ctrl_q, st_ctrl_d;
  logic        st_quiet_q, st_quiet_d;
  logic [9:0]  st_time_q, st_time_d;
  logic [23:0] st_timer_q, st_timer_d;
  logic        st_valid_q, st_valid_d;
  logic        error_q, error_d;

  logic [15:0] idle_inc;
  logic        timeout;
  logic        in_wait;

  assign idle_inc = idle_q + 16'd1;
  assign timeout  = (RX_TO != 16'd0) && (idle_inc == RX_TO);
  assign in_wait  = (state_q == S_WAIT_DATA) || (state_q == S_WAIT_STATE);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    tx_word_d    = tx_word_q;
    tx_valid_d   = tx_valid_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    wcnt_d       = wcnt_q;
    data_word_d  = data_word_q;
    data_valid_d = 1'b0;
    stg_err_d    = stg_err_q;
    stg_ctrl_d   = stg_ctrl_q;
    stg_quiet_d  = stg_quiet_q;
    stg_time_d   = stg_time_q;
    stg_tlo_d    = stg_tlo_q;
    st_err_d     = st_err_q;
    st_ctrl_d    = st_ctrl_q;
    st_quiet_d   = st_quiet_q;
    st_time_d    = st_time_q;
    st_timer_d   = st_timer_q;
    st_valid_d   = 1'b0;
    error_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          arg_d = cmd_arg;
          cnt_d = cmd_arg[15:0];
          // header is loaded at acceptance so tx_word_valid rises the next cycle
          case (cmd_op)
            3'd0: begin tx_word_d = 16'h0000; tx_valid_d = 1'b1; state_d = S_SEND_HDR; end
            3'd1: begin tx_word_d = {4'h1, 8'h00, cmd_arg[3:0]}; tx_valid_d = 1'b1; state_d = S_SEND_HDR; end
            3'd2: begin tx_word_d = {4'h2, cmd_arg[11:0]}; tx_valid_d = 1'b1; state_d = S_SEND_HDR; end
            3'd3: begin
              if (cmd_arg[15:0] == 16'd0) error_d = 1'b1;
              else begin tx_word_d = 16'h4000; tx_valid_d = 1'b1; state_d = S_SEND_HDR; end
            end
            3'd4: begin
              if (cmd_arg[15:0] == 16'd0) error_d = 1'b1;
              else begin tx_word_d = 16'h5000; tx_valid_d = 1'b1; state_d = S_SEND_HDR; end
            end
            3'd5: begin tx_word_d = {4'h6, 11'h000, cmd_arg[0]}; tx_valid_d = 1'b1; state_d = S_SEND_HDR; end
            default: error_d = 1'b1;
          endcase
        end
      end
      S_SEND_HDR: begin
        if (tx_valid_q && tx_ack) begin
          tx_valid_d = 1'b0;
          case (op_q)
            3'd2, 3'd3, 3'd4: state_d = S_SEND_ARG;
            3'd5: begin state_d = S_WAIT_STATE; idle_d = '0; wcnt_d = '0; end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_SEND_ARG: begin
        if (!tx_valid_q) begin
          tx_word_d  = (op_q == 3'd2) ? {4'h3, arg_q[23:12]} : arg_q[15:0];
          tx_valid_d = 1'b1;
        end else if (tx_ack) begin
          tx_valid_d = 1'b0;
          case (op_q)
            3'd3:    state_d = S_SEND_CFG;
            3'd4:    begin state_d = S_WAIT_DATA; idle_d = '0; end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_SEND_CFG: begin
        if (!tx_valid_q) begin
          if (cfg_valid) begin
            tx_word_d  = cfg_word;
            tx_valid_d = 1'b1;
          end
        end else if (tx_ack) begin
          tx_valid_d = 1'b0;
          cnt_d      = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (rx_word_valid) begin
          idle_d       = '0;
          data_word_d  = rx_word;
          data_valid_d = 1'b1;
          cnt_d        = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_IDLE;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_inc;
        end
      end
      S_WAIT_STATE: begin
        if (rx_word_valid) begin
          idle_d = '0;
          wcnt_d = wcnt_q + 2'd1;
          case (wcnt_q)
            2'd0: begin
              stg_err_d   = rx_word[14];
              stg_ctrl_d  = rx_word[13:10];
              stg_quiet_d = rx_word[9];
            end
            2'd1: stg_time_d = rx_word[9:0];
            2'd2: stg_tlo_d  = rx_word;
            default: begin
              st_err_d   = stg_err_q;
              st_ctrl_d  = stg_ctrl_q;
              st_quiet_d = stg_quiet_q;
              st_time_d  = stg_time_q;
              st_timer_d = {rx_word[7:0], stg_tlo_q};
              st_valid_d = 1'b1;
              state_d    = S_IDLE;
            end
          endcase
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // WAIT states start the cycle after the final ack, so words before then are dropped
    if (rx_word_valid && !in_wait) error_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      arg_q        <= '0;
      tx_word_q    <= '0;
      tx_valid_q   <= 1'b0;
      cnt_q        <= '0;
      idle_q       <= '0;
      wcnt_q       <= '0;
      data_word_q  <= '0;
      data_valid_q <= 1'b0;
      stg_err_q    <= 1'b0;
      stg_ctrl_q   <= '0;
      stg_quiet_q  <= 1'b0;
      stg_time_q   <= '0;
      stg_tlo_q    <= '0;
      st_err_q     <= 1'b0;
      st_ctrl_q    <= '0;
      st_quiet_q   <= 1'b0;
      st_time_q    <= '0;
      st_timer_q   <= '0;
      st_valid_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      tx_word_q    <= tx_word_d;
      tx_valid_q   <= tx_valid_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      wcnt_q       <= wcnt_d;
      data_word_q  <= data_word_d;
      data_valid_q <= data_valid_d;
      stg_err_q    <= stg_err_d;
      stg_ctrl_q   <= stg_ctrl_d;
      stg_quiet_q  <= stg_quiet_d;
      stg_time_q   <= stg_time_d;
      stg_tlo_q    <= stg_tlo_d;
      st_err_q     <= st_err_d;
      st_ctrl_q    <= st_ctrl_d;
      st_quiet_q   <= st_quiet_d;
      st_time_q    <= st_time_d;
      st_timer_q   <= st_timer_d;
      st_valid_q   <= st_valid_d;
      error_q      <= error_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign cfg_ready     = (state_q == S_SEND_CFG) & tx_valid_q & tx_ack & cfg_valid;
  assign tx_word       = tx_word_q;
  assign tx_word_valid = tx_valid_q;
  assign data_word     = data_word_q;
  assign data_valid    = data_valid_q;
  assign st_sim_error  = st_err_q;
  assign st_control    = st_ctrl_q;
  assign st_quiescent  = st_quiet_q;
  assign st_sim_time   = st_time_q;
  assign st_timer      = st_timer_q;
  assign st_valid      = st_valid_q;
  assign error         = error_q;

endmodule

// File: tb/tb_control_cmd_master.sv
// Scoreboard bench for control_cmd_master: directed requests push expected words,
// a negedge monitor pops and compares every tx handshake, relay, state commit and error.
module tb_control_cmd_master;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [23:0] cmd_arg = '0;
  logic [15:0] cfg_word = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] tx_word;
  logic        tx_word_valid;
  logic        tx_ack = 1'b0;
  logic [15:0] rx_word = '0;
  logic        rx_word_valid = 1'b0;
  logic [15:0] data_word;
  logic        data_valid;
  logic        st_sim_error;
  logic [3:0]  st_control;
  logic        st_quiescent;
  logic [9:0]  st_sim_time;
  logic [23:0] st_timer;
  logic        st_valid;
  logic        busy;
  logic        error;

  control_cmd_master #(.RX_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_ack(tx_ack),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid),
    .data_word(data_word), .data_valid(data_valid),
    .st_sim_error(st_sim_error), .st_control(st_control), .st_quiescent(st_quiescent),
    .st_sim_time(st_sim_time), .st_timer(st_timer), .st_valid(st_valid),
    .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cfg_pulses = 0;
  int exp_err_pending = 0;
  logic [15:0] exp_tx[$];
  logic [15:0] exp_data[$];
  logic [39:0] exp_st[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (tx_word_valid && tx_ack) begin
      check("tx_pending", 64'(exp_tx.size() != 0), 64'd1);
      if (exp_tx.size() != 0) check("tx_word", 64'(tx_word), 64'(exp_tx.pop_front()));
    end
    if (cfg_ready) cfg_pulses++;
    if (data_valid) begin
      check("data_pending", 64'(exp_data.size() != 0), 64'd1);
      if (exp_data.size() != 0) check("data_word", 64'(data_word), 64'(exp_data.pop_front()));
    end
    if (st_valid) begin
      check("st_pending", 64'(exp_st.size() != 0), 64'd1);
      if (exp_st.size() != 0)
        check("st_fields", 64'({st_sim_error, st_control, st_quiescent, st_sim_time, st_timer}),
              64'(exp_st.pop_front()));
    end
    if (error) begin
      check("err_pending", 64'(exp_err_pending > 0), 64'd1);
      if (exp_err_pending > 0) exp_err_pending--;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [23:0] arg);
    int k;
    k = 0;
    while (!cmd_ready && k < 50) begin step(); k++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic ack_words(input int n, input int hold);
    int k;
    for (int w = 0; w < n; w++) begin
      k = 0;
      while (!tx_word_valid && k < 30) begin step(); k++; end
      check("tx_valid_seen", 64'(tx_word_valid), 64'd1);
      for (int h = 0; h < hold; h++) begin
        if (exp_tx.size() != 0) check("tx_hold_word", 64'(tx_word), 64'(exp_tx[0]));
        step();
        check("tx_hold_valid", 64'(tx_word_valid), 64'd1);
      end
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
    end
  endtask

  task automatic rx_send(input logic [15:0] w);
    rx_word = w; rx_word_valid = 1'b1;
    step();
    rx_word_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_word"}, 64'(tx_word), 64'd0);
    check({tag, "_tx_valid"}, 64'(tx_word_valid), 64'd0);
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
    check({tag, "_data"}, 64'({data_word, data_valid}), 64'd0);
    check({tag, "_st"}, 64'({st_sim_error, st_control, st_quiescent, st_sim_time, st_timer, st_valid}), 64'd0);
    check({tag, "_busy_err"}, 64'({busy, error}), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  localparam logic [15:0] PAY [3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
  localparam int          GAP [3] = '{2, 0, 3};

  initial begin
    int k;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("rst");
    reset = 1'b1;
    step();

    // op 1: single COMMON word
    exp_tx.push_back(16'h100B);
    issue(3'd1, 24'h00000B);
    check("op1_tx_latency", 64'(tx_word_valid), 64'd1);
    check("op1_busy_ready", 64'({busy, cmd_ready}), 64'b10);
    ack_words(1, 0);
    check("op1_ready_back", 64'(cmd_ready), 64'd1);

    // op 2: timer low then high, ack withheld
    exp_tx.push_back(16'h2123);
    exp_tx.push_back(16'h3ABC);
    issue(3'd2, 24'hABC123);
    ack_words(2, 3);
    check("op2_idle", 64'(busy), 64'd0);

    // op 0: reset word
    exp_tx.push_back(16'h0000);
    issue(3'd0, 24'h000000);
    ack_words(1, 1);

    // op 3: config with gapped payload
    cfg_pulses = 0;
    exp_tx.push_back(16'h4000);
    exp_tx.push_back(16'h0003);
    for (int i = 0; i < 3; i++) exp_tx.push_back(PAY[i]);
    issue(3'd3, 24'h000003);
    ack_words(2, 0);
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < GAP[i]; g++) begin
        check("cfg_gap_valid_low", 64'(tx_word_valid), 64'd0);
        step();
      end
      cfg_word = PAY[i]; cfg_valid = 1'b1;
      ack_words(1, 1);
      cfg_valid = 1'b0;
    end
    check("cfg_ready_pulses", 64'(cfg_pulses), 64'd3);
    check("op3_idle", 64'(busy), 64'd0);

    // op 4: data request, two relayed words
    exp_tx.push_back(16'h5000);
    exp_tx.push_back(16'h0002);
    exp_data.push_back(16'h1111);
    exp_data.push_back(16'h2222);
    issue(3'd4, 24'h000002);
    ack_words(2, 0);
    rx_send(16'h1111);
    check("op4_relay1", 64'({data_valid, data_word}), 64'h1_1111);
    rx_send(16'h2222);
    check("op4_relay2", 64'({data_valid, data_word}), 64'h1_2222);
    check("op4_idle", 64'({busy, cmd_ready}), 64'b01);

    // op 5: state report parse
    exp_tx.push_back(16'h6001);
    exp_st.push_back({1'b1, 4'h9, 1'b1, 10'h123, 24'h894567});
    issue(3'd5, 24'h000001);
    ack_words(1, 0);
    rx_send(16'h6600);
    rx_send(16'h0123);
    rx_send(16'h4567);
    check("op5_no_early_commit", 64'(st_valid), 64'd0);
    rx_send(16'h0089);
    check("op5_st_valid", 64'(st_valid), 64'd1);
    step();
    check("op5_st_valid_pulse", 64'(st_valid), 64'd0);

    // illegal op
    exp_err_pending++;
    issue(3'd6, 24'h000000);
    check("op6_err", 64'({error, tx_word_valid, busy}), 64'b100);

    // config with zero length
    exp_err_pending++;
    issue(3'd3, 24'hFF0000);
    check("op3_n0_err", 64'({error, tx_word_valid, busy}), 64'b100);
    step();

    // stray response word while idle
    exp_err_pending++;
    rx_send(16'hDEAD);
    check("rx_idle_err", 64'({error, data_valid}), 64'b10);
    step();

    // timeout after two state words
    exp_tx.push_back(16'h6000);
    issue(3'd5, 24'h000000);
    ack_words(1, 0);
    rx_send(16'h0000);
    rx_send(16'h03FF);
    exp_err_pending++;
    k = 0;
    while (!error && k < 20) begin step(); k++; end
    check("timeout_cycles", 64'(k), 64'd8);
    check("timeout_st_kept", 64'({st_sim_error, st_control, st_quiescent, st_sim_time, st_timer}),
          64'({1'b1, 4'h9, 1'b1, 10'h123, 24'h894567}));
    check("timeout_idle", 64'(busy), 64'd0);
    step();

    // reset in the middle of a payload word
    exp_tx.push_back(16'h4000);
    exp_tx.push_back(16'h0002);
    issue(3'd3, 24'h000002);
    ack_words(2, 0);
    cfg_word = 16'h7777; cfg_valid = 1'b1;
    step();
    check("midcfg_loaded", 64'({tx_word_valid, tx_word}), 64'h1_7777);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    cfg_valid = 1'b0;
    step();
    reset = 1'b1;
    step();

    // recovery
    exp_tx.push_back(16'h1005);
    issue(3'd1, 24'h000005);
    ack_words(1, 2);
    step();

    check("end_tx_queue", 64'(exp_tx.size()), 64'd0);
    check("end_data_queue", 64'(exp_data.size()), 64'd0);
    check("end_st_queue", 64'(exp_st.size()), 64'd0);
    check("end_err_pending", 64'(exp_err_pending), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
